// File: rtl/alu_sequencer.sv
// alu_sequencer: front-end controller for an N-bit combinational ALU.
//
// Accepts an operation from either a valid/ready request port or from one of two
// debounced active-low push-buttons. It latches the operands, drives the ALU,
// waits SETTLE cycles and then registers result/carry/zero. The captured result
// is held under a valid/ready handshake.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   req_valid/req_ready           request handshake
//   req_a, req_b, req_op,         request operands, function and mode
//     req_mode                      (00 op, 01 sum, 10 subtract, 11 as 00)
//   sw_a, sw_b                    switch operands used by button requests
//   btn_sum_n, btn_subt_n         asynchronous push-buttons, low = pressed
//   alu_a, alu_b, alu_op,         ALU drive
//     alu_sum, alu_subt
//   alu_result, alu_carry         ALU response
//   res_valid/res_ready           result handshake
//   res_data, res_carry,          captured result, carry and zero flag
//     res_zero
module alu_sequencer #(
  parameter int N         = 4,
  parameter int SETTLE    = 1,
  parameter int DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic [2:0]   req_op,
  input  logic [1:0]   req_mode,
  input  logic [N-1:0] sw_a,
  input  logic [N-1:0] sw_b,
  input  logic         btn_sum_n,
  input  logic         btn_subt_n,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_sum,
  output logic         alu_subt,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_carry,
  output logic         res_zero
);

  localparam int SW = (SETTLE > 1)    ? $clog2(SETTLE)    : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t state_q, state_d;

  logic            req_ready_q, req_ready_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            alu_sum_q, alu_sum_d;
  logic            alu_subt_q, alu_subt_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic            res_valid_q, res_valid_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic            res_carry_q, res_carry_d;
  logic            res_zero_q, res_zero_d;

  // Button index 0 = sum, 1 = subtract. The synchronizer carries the inverted
  // (active-high "pressed") level, so its cleared reset value reads as released.
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          db_pressed_q, db_pressed_d;
  logic [1:0][DW-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]          press_evt;

  // Debounce: count consecutive samples that disagree with the accepted level;
  // after DB_CYCLES of them the accepted level flips. A press event fires only
  // on the released->pressed flip, so a held button cannot repeat.
  always_comb begin
    db_cnt_d     = '0;
    db_pressed_d = db_pressed_q;
    press_evt    = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_pressed_q[i]) begin
        if (db_cnt_q[i] == DW'(DB_CYCLES - 1)) begin
          db_pressed_d[i] = sync2_q[i];
          press_evt[i]    = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_sum_d    = alu_sum_q;
    alu_subt_d   = alu_subt_q;
    settle_cnt_d = settle_cnt_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_carry_d  = res_carry_q;
    res_zero_d   = res_zero_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        // req_ready_q is low only on the first cycle after reset release.
        if (req_ready_q && req_valid) begin
          alu_a_d      = req_a;
          alu_b_d      = req_b;
          alu_op_d     = req_op;
          alu_sum_d    = (req_mode == 2'b01);
          alu_subt_d   = (req_mode == 2'b10);
          req_ready_d  = 1'b0;
          settle_cnt_d = '0;
          state_d      = DRIVE;
        end else if (req_ready_q && (|press_evt)) begin
          alu_a_d      = sw_a;
          alu_b_d      = sw_b;
          alu_op_d     = 3'b000;
          alu_sum_d    = press_evt[0];
          alu_subt_d   = ~press_evt[0];
          req_ready_d  = 1'b0;
          settle_cnt_d = '0;
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt_q == SW'(SETTLE - 1)) begin
          res_data_d  = alu_result;
          res_carry_d = alu_carry;
          res_zero_d  = (alu_result == '0);
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_sum_q    <= 1'b0;
      alu_subt_q   <= 1'b0;
      settle_cnt_q <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      res_zero_q   <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_pressed_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_sum_q    <= alu_sum_d;
      alu_subt_q   <= alu_subt_d;
      settle_cnt_q <= settle_cnt_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_carry_q  <= res_carry_d;
      res_zero_q   <= res_zero_d;
      sync1_q      <= {~btn_subt_n, ~btn_sum_n};
      sync2_q      <= sync1_q;
      db_pressed_q <= db_pressed_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_sum   = alu_sum_q;
  assign alu_subt  = alu_subt_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a small behavioural ALU answers the DUT, stimulus
// pushes hand-computed expected results into a scoreboard, and a monitor pops
// and compares on every result handshake.
module tb_alu_sequencer;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a, req_b;
  logic [2:0]   req_op;
  logic [1:0]   req_mode;
  logic [N-1:0] sw_a, sw_b;
  logic         btn_sum_n, btn_subt_n;
  logic [N-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic         alu_sum, alu_subt;
  logic [N-1:0] alu_result;
  logic         alu_carry;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_carry, res_zero;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .SETTLE(1), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mode(req_mode),
    .sw_a(sw_a), .sw_b(sw_b),
    .btn_sum_n(btn_sum_n), .btn_subt_n(btn_subt_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sum(alu_sum), .alu_subt(alu_subt),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero)
  );

  // Behavioural ALU: sum/subtract override op; carry is the 5th result bit.
  logic [N:0] alu_full;
  always_comb begin
    alu_full = '0;
    if (alu_sum)       alu_full = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_subt) alu_full = {1'b0, alu_a} - {1'b0, alu_b};
    else begin
      case (alu_op)
        3'b000:  alu_full = {1'b0, alu_a & alu_b};
        3'b001:  alu_full = {1'b0, alu_a | alu_b};
        3'b010:  alu_full = {1'b0, alu_a ^ alu_b};
        3'b011:  alu_full = {1'b0, ~alu_a};
        3'b100:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
        3'b101:  alu_full = {1'b0, alu_a} - {1'b0, alu_b};
        3'b110:  alu_full = {alu_a, 1'b0};
        default: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      endcase
    end
  end
  assign alu_result = alu_full[N-1:0];
  assign alu_carry  = alu_full[N];

  typedef struct packed {
    logic [N-1:0] data;
    logic         carry;
    logic         zero;
    logic [2:0]   op;
    logic         sum;
    logic         subt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: actual res_data=%b, required no pending op (t=%0t)",
                 res_data, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_data",  res_data,  e.data);
        chk("res_carry", res_carry, e.carry);
        chk("res_zero",  res_zero,  e.zero);
        chk("alu_op",    alu_op,    e.op);
        chk("alu_sum",   alu_sum,   e.sum);
        chk("alu_subt",  alu_subt,  e.subt);
      end
    end
  end

  task automatic wait_ready();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (req_ready) seen = 1;
    end
    if (!seen) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic send_req(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                          input logic [1:0] mode, input exp_t e, input bit check_lat);
    wait_ready();
    sb_q.push_back(e);
    req_a = a; req_b = b; req_op = op; req_mode = mode; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_after_accept", req_ready, 0);
    chk("res_valid_at_accept", res_valid, 0);
    if (check_lat) begin
      @(posedge clk); #1;
      chk("res_valid_latency", res_valid, 1);
    end
  endtask

  task automatic press(input bit do_sum, input bit do_subt, input int low_cycles);
    @(posedge clk); #1;
    if (do_sum)  btn_sum_n  = 1'b0;
    if (do_subt) btn_subt_n = 1'b0;
    repeat (low_cycles) @(posedge clk);
    #1;
    btn_sum_n  = 1'b1;
    btn_subt_n = 1'b1;
    repeat (DB + 10) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_mode = '0;
    sw_a = '0; sw_b = '0; btn_sum_n = 1'b1; btn_subt_n = 1'b1; res_ready = 1'b1;

    // Reset state and first edge after release
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu_sum",   alu_sum,   0);
    chk("rst_res_data",  res_data,  0);
    #1 rst_n = 1'b1;
    chk("req_ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    chk("req_ready_after_release", req_ready, 1);

    // 1: op-function request (op 111 in the bench ALU is a+b)
    send_req(4'b1000, 4'b1000, 3'b111, 2'b00, '{4'b0000, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0}, 1);
    chk("alu_a_latched", alu_a, 4'b1000);
    // Request modes 01, 10 and 11
    send_req(4'b0110, 4'b0011, 3'b010, 2'b01, '{4'b1001, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0}, 1);
    send_req(4'b0011, 4'b0110, 3'b001, 2'b10, '{4'b1101, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1}, 1);
    send_req(4'b1100, 4'b1010, 3'b010, 2'b11, '{4'b0110, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0}, 1);
    wait_ready();

    // 2: sum button held DB+2 cycles -> one op
    sw_a = 4'b1111; sw_b = 4'b1000;
    sb_q.push_back('{4'b0111, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0});
    press(1, 0, DB + 2);
    chk("btn_sum_alu_a", alu_a, 4'b1111);

    // 3: subtract button held long (no repeat), then a short glitch (no op)
    sw_a = 4'b1111; sw_b = 4'b1111;
    sb_q.push_back('{4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1});
    press(0, 1, 20);
    press(0, 1, 2);
    chk("glitch_no_res_valid", res_valid, 0);
    chk("glitch_no_pending", sb_q.size(), 0);

    // 4: result held in DONE while requests and a button press are applied
    res_ready = 1'b0;
    send_req(4'b0110, 4'b0011, 3'b010, 2'b01, '{4'b1001, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0}, 1);
    req_a = 4'b0001; req_b = 4'b0001; req_mode = 2'b00; req_valid = 1'b1;
    sw_a = 4'b1010; sw_b = 4'b0101; btn_sum_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("done_res_data",  res_data,  4'b1001);
      chk("done_res_valid", res_valid, 1);
      chk("done_req_ready", req_ready, 0);
    end
    chk("done_alu_a_held", alu_a, 4'b0110);
    @(posedge clk); #1;
    req_valid = 1'b0; btn_sum_n = 1'b1;
    repeat (DB + 4) @(posedge clk);
    #1 res_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_queued_op", res_valid, 0);
    chk("res_data_held_after_hs", res_data, 4'b1001);

    // 5: request and button event in the same IDLE cycle -> request wins
    wait_ready();
    sw_a = 4'b1111; sw_b = 4'b1000;
    @(posedge clk); #1 btn_sum_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sb_q.push_back('{4'b0001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    req_a = 4'b0011; req_b = 4'b0001; req_op = 3'b000; req_mode = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("simul_alu_a_is_req", alu_a, 4'b0011);
    btn_sum_n = 1'b1;
    repeat (DB + 10) @(posedge clk);
    #1;
    // Both buttons together -> sum
    sw_a = 4'b0101; sw_b = 4'b0011;
    sb_q.push_back('{4'b1000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0});
    press(1, 1, DB + 2);

    // 6: reset while in DRIVE
    wait_ready();
    req_a = 4'b0111; req_b = 4'b0111; req_op = 3'b100; req_mode = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_alu_a",     alu_a,     0);
    chk("mid_rst_alu_op",    alu_op,    0);
    chk("mid_rst_res_data",  res_data,  0);
    chk("mid_rst_res_carry", res_carry, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    chk("post_rst_ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_req_ready", req_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_stale_valid", res_valid, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
